// File: rtl/da_01_pkg.sv
// Shared widths, index type and reset value for the da_01 priority encoder.
package da_01_pkg;

    localparam int IN_W  = 4;
    localparam int IDX_W = 2;

    typedef logic [IDX_W-1:0] idx_t;

    localparam idx_t IDX_RST = 2'b00;

endpackage : da_01_pkg

// File: rtl/da_01_if.sv
// Request bits in, registered index bits out; master drives requests, slave is the encoder.
interface da_01_if;

    logic in3;
    logic in2;
    logic in1;
    logic in0;
    logic out1;
    logic out0;

    modport master (
        output in3, in2, in1, in0,
        input  out1, out0
    );

    modport slave (
        input  in3, in2, in1, in0,
        output out1, out0
    );

endinterface : da_01_if

// File: rtl/da_01_prio_enc.sv
// Combinational 4:2 priority encoder; the highest-numbered set bit wins.
module da_01_prio_enc
    import da_01_pkg::*;
(
    input  logic [IN_W-1:0] i_vec,
    output idx_t            o_idx,
    output logic            o_any
);

    // Ascending scan so a later (higher) set bit overrides any lower one.
    always_comb begin
        o_idx = IDX_RST;
        for (int i = 0; i < IN_W; i++) begin
            if (i_vec[i]) begin
                o_idx = idx_t'(i);
            end
        end
    end

    assign o_any = |i_vec;

endmodule : da_01_prio_enc

// File: rtl/da_01.sv
// Registered priority encoder: loads the MSB index when any request is set, else holds.
module da_01
    import da_01_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    da_01_if.slave  bus
);

    logic [IN_W-1:0] w_vec;
    idx_t            w_idx;
    logic            w_any;
    idx_t            r_idx;

    assign w_vec = {bus.in3, bus.in2, bus.in1, bus.in0};

    da_01_prio_enc u_prio_enc (
        .i_vec (w_vec),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx <= IDX_RST;
        end else if (w_any) begin
            r_idx <= w_idx;
        end
    end

    assign bus.out1 = r_idx[1];
    assign bus.out0 = r_idx[0];

endmodule : da_01

// File: tb/tb_da_01.sv
// Directed table-driven bench for da_01 with hand-written reset and latency sequences.
module tb_da_01;

    logic clk;
    logic rst;

    da_01_if bus_if ();

    da_01 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    typedef struct {
        logic [3:0] vec;
        logic [1:0] exp;
    } vec_t;

    vec_t vectors [0:22];
    int   checks;
    int   errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    function automatic logic [1:0] get_out();
        return {bus_if.out1, bus_if.out0};
    endfunction

    task automatic check(input string name, input logic [3:0] vec,
                         input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: in=%b out=%b expected=%b", name, vec, act, exp);
        end else begin
            $display("ok   %s: in=%b out=%b", name, vec, act);
        end
    endtask

    task automatic set_in(input logic [3:0] vec);
        {bus_if.in3, bus_if.in2, bus_if.in1, bus_if.in0} = vec;
    endtask

    task automatic apply(input string name, input logic [3:0] vec, input logic [1:0] exp);
        @(negedge clk);
        set_in(vec);
        @(posedge clk);
        #1;
        check(name, vec, get_out(), exp);
    endtask

    initial begin
        checks = 0;
        errors = 0;

        // Sweep starts with outputs at 11 (left by the reset-release check).
        vectors[0]  = '{4'b0000, 2'b11};
        vectors[1]  = '{4'b0001, 2'b00};
        vectors[2]  = '{4'b0010, 2'b01};
        vectors[3]  = '{4'b0011, 2'b01};
        vectors[4]  = '{4'b0100, 2'b10};
        vectors[5]  = '{4'b0101, 2'b10};
        vectors[6]  = '{4'b0110, 2'b10};
        vectors[7]  = '{4'b0111, 2'b10};
        vectors[8]  = '{4'b1000, 2'b11};
        vectors[9]  = '{4'b1001, 2'b11};
        vectors[10] = '{4'b1010, 2'b11};
        vectors[11] = '{4'b1011, 2'b11};
        vectors[12] = '{4'b1100, 2'b11};
        vectors[13] = '{4'b1101, 2'b11};
        vectors[14] = '{4'b1110, 2'b11};
        vectors[15] = '{4'b1111, 2'b11};
        vectors[16] = '{4'b0000, 2'b11};
        vectors[17] = '{4'b0100, 2'b10};
        vectors[18] = '{4'b0000, 2'b10};
        vectors[19] = '{4'b0000, 2'b10};
        vectors[20] = '{4'b0000, 2'b10};
        vectors[21] = '{4'b0000, 2'b10};
        vectors[22] = '{4'b0000, 2'b10};

        // Reset asserted with a request pending: output must stay 00 across edges.
        rst = 1'b1;
        set_in(4'b1000);
        #1;
        check("reset_async", 4'b1000, get_out(), 2'b00);
        repeat (2) @(posedge clk);
        #1;
        check("reset_hold", 4'b1000, get_out(), 2'b00);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("reset_release", 4'b1000, get_out(), 2'b11);

        for (int i = 0; i < 23; i++) begin
            apply($sformatf("vec%0d", i), vectors[i].vec, vectors[i].exp);
        end

        // Latency: mid-cycle input change has no effect until the next edge.
        apply("lat_base", 4'b0001, 2'b00);
        #2;
        set_in(4'b1000);
        #1;
        check("lat_midcycle", 4'b1000, get_out(), 2'b00);
        @(posedge clk);
        #1;
        check("lat_edge", 4'b1000, get_out(), 2'b11);

        // Mid-operation reset pulse between edges.
        #2;
        rst = 1'b1;
        #1;
        check("midrst_async", 4'b1000, get_out(), 2'b00);
        #1;
        rst = 1'b0;
        set_in(4'b0010);
        @(posedge clk);
        #1;
        check("midrst_release", 4'b0010, get_out(), 2'b01);

        // All-zero input right after reset holds the reset value.
        #2;
        rst = 1'b1;
        #1;
        check("zero_rst_async", 4'b0010, get_out(), 2'b00);
        #1;
        rst = 1'b0;
        set_in(4'b0000);
        @(posedge clk);
        #1;
        check("zero_after_rst", 4'b0000, get_out(), 2'b00);
        apply("zero_after_rst2", 4'b0000, 2'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_da_01
